// File: rtl/tri_fetch_arbiter.sv
// tri_fetch_arbiter: round-robin, burst-locked sharing of the triangle RAM read port between two traversal lanes.
// Latency: ready/ram_en/ram_addr are combinational with the request; the lane's response is valid RD_LAT cycles after its handshake.
// Backpressure: the non-owning lane sees ready=0 while a burst is open; responses cannot be stalled. Optional TRI_ARB_STATS_EN adds counters.
module tri_fetch_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 128,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_last,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  input  logic              req1_last,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef TRI_ARB_STATS_EN
  ,
  output logic [31:0]       stat_grant0,
  output logic [31:0]       stat_grant1,
  output logic [31:0]       stat_conflict
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              prio, prio_nxt;
  logic              grant0, grant1;
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_lane;

  // Grant selection; a non-last beat locks the port to its lane, a last beat releases it and hands priority to the other lane
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    state_nxt = state;
    prio_nxt  = prio;
    case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || !prio)) grant0 = 1'b1;
        else if (req1_valid)                      grant1 = 1'b1;
      end
      LOCK0:   grant0 = req0_valid;
      LOCK1:   grant1 = req1_valid;
      default: state_nxt = IDLE;
    endcase
    if (grant0) begin
      state_nxt = req0_last ? IDLE : LOCK0;
      if (req0_last) prio_nxt = 1'b1;
    end else if (grant1) begin
      state_nxt = req1_last ? IDLE : LOCK1;
      if (req1_last) prio_nxt = 1'b0;
    end
  end

  // Lock state and round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign ram_en     = grant0 | grant1;
  assign ram_addr   = grant0 ? req0_addr : (grant1 ? req1_addr : '0);
  assign rsp_data   = ram_rdata;

  // Tag pipeline tracking which lane owns each read in flight through the RAM
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_vld  <= '0;
      tag_lane <= '0;
    end else begin
      tag_vld[0]  <= ram_en;
      tag_lane[0] <= grant1;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_lane[i] <= tag_lane[i-1];
      end
    end
  end

  // Reads accepted before a reset never answer, including one landing in the reset cycle itself
  assign rsp0_valid = tag_vld[RD_LAT-1] & ~tag_lane[RD_LAT-1] & ~reset;
  assign rsp1_valid = tag_vld[RD_LAT-1] &  tag_lane[RD_LAT-1] & ~reset;

`ifdef TRI_ARB_STATS_EN
  logic conflict;
  assign conflict = (req0_valid & ~grant0) | (req1_valid & ~grant1);

  // Free-running wrap-around counters of grants per lane and stalled-request cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (grant0)   stat_grant0   <= stat_grant0 + 32'd1;
      if (grant1)   stat_grant1   <= stat_grant1 + 32'd1;
      if (conflict) stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tri_fetch_arbiter.sv
// Bench for tri_fetch_arbiter: hand-derived vector table, stats check, then random traffic against a reference model.
// Responses are checked through a scoreboard of {due cycle, lane, addr}; the RAM model returns a word derived from the address.
// Inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
module tb_tri_fetch_arbiter;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 128;
  localparam int RD_LAT = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              req0_valid, req0_last, req0_ready, rsp0_valid;
  logic              req1_valid, req1_last, req1_ready, rsp1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr, ram_addr;
  logic [DATA_W-1:0] rsp_data, ram_rdata;
  logic              ram_en;
`ifdef TRI_ARB_STATS_EN
  logic [31:0]       stat_grant0, stat_grant1, stat_conflict;
`endif

  always #5 clock = ~clock;

  tri_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_last(req0_last), .req0_addr(req0_addr),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_last(req1_last), .req1_addr(req1_addr),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata)
`ifdef TRI_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
  );

  // RAM model: the word for an address is a fixed scramble of it, delivered RD_LAT cycles after ram_en
  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return {12'hC0F, a, ~a, 12'h3E1, 12'h000, a ^ 20'hABCDE, a, 12'h5A5};
  endfunction

  logic              ram_pipe_en   [RD_LAT];
  logic [ADDR_W-1:0] ram_pipe_addr [RD_LAT];
  always @(posedge clock) begin
    ram_pipe_en[0]   <= ram_en;
    ram_pipe_addr[0] <= ram_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      ram_pipe_en[i]   <= ram_pipe_en[i-1];
      ram_pipe_addr[i] <= ram_pipe_addr[i-1];
    end
  end
  assign ram_rdata = ram_pipe_en[RD_LAT-1] ? ram_word(ram_pipe_addr[RD_LAT-1]) : {4{32'hDEAD_BEEF}};

  typedef struct {
    int                due;
    logic              lane;
    logic [ADDR_W-1:0] addr;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0b required=%0b", name, cyc, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive, check grant outputs and the scoreboard head at mid-cycle, record the expected handshake
  task automatic cycle(input logic rst, input logic v0, input logic l0, input logic [ADDR_W-1:0] a0,
                       input logic v1, input logic l1, input logic [ADDR_W-1:0] a1,
                       input logic e0, input logic e1);
    logic [ADDR_W-1:0] ea;
    reset = rst;
    req0_valid = v0; req0_last = l0; req0_addr = a0;
    req1_valid = v1; req1_last = l1; req1_addr = a1;
    #4;
    chk1("req0_ready", req0_ready, e0);
    chk1("req1_ready", req1_ready, e1);
    chk1("ram_en", ram_en, e0 | e1);
    ea = e0 ? a0 : (e1 ? a1 : '0);
    chkw("ram_addr", 128'(ram_addr), 128'(ea));
    if (!rst && sb.size() > 0 && sb[0].due == cyc) begin
      chk1("rsp0_valid", rsp0_valid, !sb[0].lane);
      chk1("rsp1_valid", rsp1_valid, sb[0].lane);
      chkw("rsp_data", rsp_data, ram_word(sb[0].addr));
      void'(sb.pop_front());
    end else begin
      chk1("rsp0_valid_idle", rsp0_valid, 1'b0);
      chk1("rsp1_valid_idle", rsp1_valid, 1'b0);
    end
    if (rst) sb.delete();
    else if (e0) sb.push_back('{cyc + RD_LAT, 1'b0, a0});
    else if (e1) sb.push_back('{cyc + RD_LAT, 1'b1, a1});
    @(posedge clock);
    #1;
    cyc++;
  endtask

  typedef struct {
    logic              rst, v0, l0;
    logic [ADDR_W-1:0] a0;
    logic              v1, l1;
    logic [ADDR_W-1:0] a1;
    logic              e0, e1;
  } vec_t;

  function automatic vec_t mk(input int rst, input int v0, input int l0, input int a0,
                              input int v1, input int l1, input int a1, input int e0, input int e1);
    vec_t r;
    r.rst = rst[0]; r.v0 = v0[0]; r.l0 = l0[0]; r.a0 = a0[ADDR_W-1:0];
    r.v1 = v1[0];   r.l1 = l1[0]; r.a1 = a1[ADDR_W-1:0];
    r.e0 = e0[0];   r.e1 = e1[0];
    return r;
  endfunction

  vec_t vecs[$];

  // Random-phase reference state
  int                m_state;
  logic              m_prio;
  logic              pv [2];
  logic              pl [2];
  logic [ADDR_W-1:0] pa [2];
  logic              g0, g1;
  int                hs;

  initial begin
    // reset, idle, single beat to 0x10 (response two cycles later on lane 0 only)
    vecs.push_back(mk(1,0,0,0,    0,0,0,    0,0));
    vecs.push_back(mk(1,0,0,0,    0,0,0,    0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,0,    0,0));
    vecs.push_back(mk(0,1,1,'h10, 0,0,0,    1,0));
    vecs.push_back(mk(0,0,0,0,    0,0,0,    0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,0,    0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,0,    0,0));
    // reset restores prio=0: contention grants 0x5 then 0x9
    vecs.push_back(mk(1,0,0,0,    0,0,0,    0,0));
    vecs.push_back(mk(0,1,1,'h5,  1,1,'h9,  1,0));
    vecs.push_back(mk(0,0,0,0,    1,1,'h9,  0,1));
    vecs.push_back(mk(0,0,0,0,    0,0,0,    0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,0,    0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,0,    0,0));
    // lane 1 burst 0x20..0x23 with a one-cycle gap; lane 0 stalls through the bubble
    vecs.push_back(mk(0,0,0,0,    1,0,'h20, 0,1));
    vecs.push_back(mk(0,1,1,'h40, 1,0,'h21, 0,1));
    vecs.push_back(mk(0,1,1,'h40, 0,0,0,    0,0));
    vecs.push_back(mk(0,1,1,'h40, 1,0,'h22, 0,1));
    vecs.push_back(mk(0,1,1,'h40, 1,1,'h23, 0,1));
    vecs.push_back(mk(0,1,1,'h40, 0,0,0,    1,0));
    // prio=1: lane 1 wins the tie and holds lane 0 off until its last beat
    vecs.push_back(mk(0,1,1,'h41, 1,0,'h30, 0,1));
    vecs.push_back(mk(0,1,1,'h41, 1,1,'h31, 0,1));
    vecs.push_back(mk(0,1,1,'h41, 0,0,0,    1,0));
    vecs.push_back(mk(0,0,0,0,    0,0,0,    0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,0,    0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,0,    0,0));
    // reset mid-burst with two reads in flight: no responses, lock released
    vecs.push_back(mk(0,1,0,'h50, 0,0,0,    1,0));
    vecs.push_back(mk(0,1,0,'h51, 0,0,0,    1,0));
    vecs.push_back(mk(1,0,0,0,    0,0,0,    0,0));
    vecs.push_back(mk(0,0,0,0,    1,0,'h60, 0,1));
    vecs.push_back(mk(0,0,0,0,    1,1,'h61, 0,1));
    vecs.push_back(mk(0,0,0,0,    0,0,0,    0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,0,    0,0));
    vecs.push_back(mk(0,0,0,0,    0,0,0,    0,0));

    reset = 1'b1;
    req0_valid = 1'b0; req0_last = 1'b0; req0_addr = '0;
    req1_valid = 1'b0; req1_last = 1'b0; req1_addr = '0;
    @(posedge clock);
    #1;

    foreach (vecs[k])
      cycle(vecs[k].rst, vecs[k].v0, vecs[k].l0, vecs[k].a0,
            vecs[k].v1, vecs[k].l1, vecs[k].a1, vecs[k].e0, vecs[k].e1);

`ifdef TRI_ARB_STATS_EN
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 20'h5, 1'b1, 1'b1, 20'h9, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 20'h9, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chkw("stat_grant0", 128'(stat_grant0), 128'(32'd1));
    chkw("stat_grant1", 128'(stat_grant1), 128'(32'd1));
    chkw("stat_conflict", 128'(stat_conflict), 128'(32'd1));
`endif

    // Random mixed traffic, bounded by a cycle budget
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    m_state = 0; m_prio = 1'b0; hs = 0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    pl[0] = 1'b0; pl[1] = 1'b0;
    pa[0] = '0;   pa[1] = '0;
    for (int n = 0; n < 20000 && hs < 1000; n++) begin
      for (int l = 0; l < 2; l++) begin
        if (!pv[l] && $urandom_range(0, 3) != 0) begin
          pv[l] = 1'b1;
          pl[l] = ($urandom_range(0, 2) == 0);
          pa[l] = ADDR_W'($urandom);
        end
      end
      g0 = 1'b0; g1 = 1'b0;
      case (m_state)
        0: begin
          if (pv[0] && (!pv[1] || !m_prio)) g0 = 1'b1;
          else if (pv[1])                   g1 = 1'b1;
        end
        1:       g0 = pv[0];
        default: g1 = pv[1];
      endcase
      cycle(1'b0, pv[0], pl[0], pa[0], pv[1], pl[1], pa[1], g0, g1);
      if (g0) begin
        m_state = pl[0] ? 0 : 1;
        if (pl[0]) m_prio = 1'b1;
        pv[0] = 1'b0;
        hs++;
      end else if (g1) begin
        m_state = pl[1] ? 0 : 2;
        if (pl[1]) m_prio = 1'b0;
        pv[1] = 1'b0;
        hs++;
      end
    end
    chkw("random_handshakes", 128'(hs), 128'(1000));
    repeat (RD_LAT + 1) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chkw("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
